// File: rtl/riscv_boot_pkg.sv
// riscv_boot_pkg: shared types and constants for the riscv_boot_loader slice.
// Holds the loader state encoding, the registered status-flag bundle and the
// helper that maps a state to its status flags.
package riscv_boot_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = 16;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } boot_state_t;

    // Status outputs that depend only on the loader state.
    typedef struct packed {
        logic s_ready;
        logic busy;
        logic done;
        logic error;
        logic core_rst;
    } boot_flags_t;

    localparam boot_flags_t FLAGS_RST = '{
        s_ready:  1'b0,
        busy:     1'b0,
        done:     1'b0,
        error:    1'b0,
        core_rst: 1'b1
    };

    // Status flags presented while the loader sits in state st.
    function automatic boot_flags_t flags_of(input boot_state_t st);
        boot_flags_t f;
        f = FLAGS_RST;
        case (st)
            LEN_LO: f.s_ready = 1'b1;
            LEN_HI, PAYLOAD, CHECK: begin
                f.s_ready = 1'b1;
                f.busy    = 1'b1;
            end
            DONE: begin
                f.done     = 1'b1;
                f.core_rst = 1'b0;
            end
            ERROR:   f.error = 1'b1;
            default: f = FLAGS_RST;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/riscv_boot_loader_if.sv
// riscv_boot_loader_if: byte-stream valid/ready channel into the boot loader.
//   s_valid : source has a byte
//   s_data  : the byte
//   s_ready : loader accepts a byte this cycle
// master = byte source, slave = loader.
interface riscv_boot_loader_if;
    import riscv_boot_pkg::*;

    logic              s_valid;
    logic [BYTE_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/riscv_boot_word_packer.sv
// riscv_boot_word_packer: packs accepted bytes little-endian into 32-bit words.
//   clk, rst_n   : clock, async active-low reset
//   clear        : restart at byte lane 0 (start of a new payload)
//   byte_en      : a payload byte is accepted this cycle
//   byte_in      : the payload byte
//   last_lane_c  : combinational, next accepted byte completes the word
//   word_valid   : registered one-cycle pulse, word holds a completed word
//   word         : registered completed word, held between pulses
import riscv_boot_pkg::*;

module riscv_boot_word_packer (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              last_lane_c,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned ASM_W  = WORD_W - BYTE_W;

    logic [LANE_W-1:0] lane_q;
    logic [ASM_W-1:0]  asm_q;

    assign last_lane_c = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

    // Lower lanes collect in asm_q; the top lane completes the word directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= '0;
            asm_q      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane_q <= '0;
            end else if (byte_en) begin
                if (last_lane_c) begin
                    word       <= {byte_in, asm_q};
                    word_valid <= 1'b1;
                    lane_q     <= '0;
                end else begin
                    asm_q[int'(lane_q) * BYTE_W +: BYTE_W] <= byte_in;
                    lane_q <= lane_q + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/riscv_boot_loader.sv
// riscv_boot_loader: loads a length-prefixed byte image into instruction
// memory and holds the core in reset until the image is complete.
//   clk, rst_n  : clock, async active-low reset
//   s           : byte stream (riscv_boot_loader_if.slave)
//   reload      : pulse; restarts loading from DONE or ERROR
//   imem_we     : one-cycle instruction memory write strobe
//   imem_addr   : word address, held between writes
//   imem_wdata  : instruction word
//   core_rst    : active-high reset to the core
//   busy/done/error : load status
// Build option: define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
import riscv_boot_pkg::*;

module riscv_boot_loader #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    riscv_boot_loader_if.slave     s,
    input  logic                   reload,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [WORD_W-1:0]      imem_wdata,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t TAIL_ST = CHECK;
`else
    localparam boot_state_t TAIL_ST = DONE;
`endif

    boot_state_t       state;
    boot_flags_t       flags;
    logic [BYTE_W-1:0] len_lo_q;
    logic [LEN_W-1:0]  n_last_q;
    logic [LEN_W-1:0]  word_idx_q;
    logic [ADDR_W-1:0] imem_addr_q;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;
`endif

    logic             accept_c;
    logic [LEN_W-1:0] len_c;
    logic             pack_en_c;
    logic             pack_clr_c;
    logic             last_lane_c;

    assign accept_c   = s.s_valid && flags.s_ready;
    assign len_c      = {s.s_data, len_lo_q};
    assign pack_en_c  = accept_c && (state == PAYLOAD);
    assign pack_clr_c = accept_c && (state == LEN_HI);

    riscv_boot_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (pack_clr_c),
        .byte_en     (pack_en_c),
        .byte_in     (s.s_data),
        .last_lane_c (last_lane_c),
        .word_valid  (imem_we),
        .word        (imem_wdata)
    );

    // Loader FSM; status flags are re-registered from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LEN_LO;
            flags       <= FLAGS_RST;
            len_lo_q    <= '0;
            n_last_q    <= '0;
            word_idx_q  <= '0;
            imem_addr_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            flags <= flags_of(state);
            case (state)
                LEN_LO: begin
                    if (accept_c) begin
                        len_lo_q <= s.s_data;
                        state    <= LEN_HI;
                        flags    <= flags_of(LEN_HI);
                    end
                end
                LEN_HI: begin
                    if (accept_c) begin
                        word_idx_q <= '0;
`ifdef BOOT_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        if (len_c > LEN_W'(IMEM_DEPTH)) begin
                            state <= ERROR;
                            flags <= flags_of(ERROR);
                        end else if (len_c == '0) begin
                            state <= TAIL_ST;
                            flags <= flags_of(TAIL_ST);
                        end else begin
                            n_last_q <= len_c - LEN_W'(1);
                            state    <= PAYLOAD;
                            flags    <= flags_of(PAYLOAD);
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept_c) begin
`ifdef BOOT_CHECKSUM_EN
                        csum_q <= csum_q ^ s.s_data;
`endif
                        // Address is registered alongside the packer's word pulse.
                        if (last_lane_c) begin
                            imem_addr_q <= ADDR_W'(word_idx_q);
                            if (word_idx_q == n_last_q) begin
                                state <= TAIL_ST;
                                flags <= flags_of(TAIL_ST);
                            end else begin
                                word_idx_q <= word_idx_q + LEN_W'(1);
                            end
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (accept_c) begin
                        if (s.s_data == csum_q) begin
                            state <= DONE;
                            flags <= flags_of(DONE);
                        end else begin
                            state <= ERROR;
                            flags <= flags_of(ERROR);
                        end
                    end
                end
`endif
                DONE, ERROR: begin
                    if (reload) begin
                        state <= LEN_LO;
                        flags <= flags_of(LEN_LO);
                    end
                end
                default: begin
                    state <= LEN_LO;
                    flags <= flags_of(LEN_LO);
                end
            endcase
        end
    end

    assign s.s_ready = flags.s_ready;
    assign busy      = flags.busy;
    assign done      = flags.done;
    assign error     = flags.error;
    assign core_rst  = flags.core_rst;
    assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// tb_riscv_boot_loader: randomized and directed image loads against a
// behavioural image model (length header, little-endian words, optional
// XOR checksum when BOOT_CHECKSUM_EN is defined).
module tb_riscv_boot_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic reload = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic core_rst, busy, done, error;

    riscv_boot_loader_if bus();

    riscv_boot_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (bus),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int tmo_cnt  = 0;
    int viol     = 0;
    logic [AW+31:0] got_q[$];
    logic [AW+31:0] exp_q[$];
    logic [7:0]     img_q[$];
    bit             exp_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write capture and status-consistency watch.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_we) got_q.push_back({imem_addr, imem_wdata});
            if ((done && core_rst) || (error && !core_rst) || (done && error) ||
                (busy && (done || error)))
                viol++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected writes and outcome straight from the image format.
    task automatic model(input logic [7:0] img[$]);
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        exp_err = 1'b0;
        n = int'(img[0]) + 256 * int'(img[1]);
        if (n > int'(DEPTH)) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                w = w | (32'(img[2 + 4*i + k]) << (8*k));
                x = x ^ img[2 + 4*i + k];
            end
            exp_q.push_back({AW'(i), w});
        end
`ifdef BOOT_CHECKSUM_EN
        if (img[2 + 4*n] != x) exp_err = 1'b1;
`endif
    endtask

    task automatic add_csum(input bit bad);
`ifdef BOOT_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < img_q.size(); i++) x = x ^ img_q[i];
        img_q.push_back(bad ? (x ^ 8'h5a) : x);
`else
        if (bad) img_q.push_back(8'h00);
`endif
    endtask

    task automatic make_img(input int n, input bit bad);
        img_q.delete();
        img_q.push_back(8'(n));
        img_q.push_back(8'(n >> 8));
        if (n <= int'(DEPTH)) begin
            for (int i = 0; i < 4*n; i++) img_q.push_back(8'($urandom));
            add_csum(bad);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        for (int i = 0; i < 64; i++) begin
            if (bus.s_ready) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) tmo_cnt++;
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_s_ready"},  bus.s_ready, 0);
        check({tag, "_we"},       imem_we,     0);
        check({tag, "_addr"},     imem_addr,   0);
        check({tag, "_wdata"},    imem_wdata,  0);
        check({tag, "_core_rst"}, core_rst,    1);
        check({tag, "_busy"},     busy,        0);
        check({tag, "_done"},     done,        0);
        check({tag, "_error"},    error,       0);
    endtask

    task automatic pulse_reload_if_idle();
        if (done || error) begin
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
        end
    endtask

    task automatic run_load(input string tag, input int gmin, input int gmax, input bit noise);
        int g;
        pulse_reload_if_idle();
        got_q.delete();
        model(img_q);
        tmo_cnt = 0;
        for (int i = 0; i < img_q.size(); i++) begin
            if (i > 0 && gmax > 0) begin
                g = $urandom_range(gmax, gmin);
                bus.s_valid = 1'b0;
                repeat (g) begin
                    bus.s_data = 8'($urandom);
                    reload = noise & 1'($urandom);
                    @(negedge clk);
                    reload = 1'b0;
                end
            end
            send_byte(img_q[i]);
            if (i == 0) check({tag, "_busy_lenhi"}, busy, 1);
        end
        bus.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), (i < got_q.size()) ? got_q[i] : '1, exp_q[i]);
        check({tag, "_done"},     done,        !exp_err);
        check({tag, "_error"},    error,       exp_err);
        check({tag, "_core_rst"}, core_rst,    exp_err);
        check({tag, "_s_ready"},  bus.s_ready, 0);
        check({tag, "_busy"},     busy,        0);
        check({tag, "_timeouts"}, tmo_cnt,     0);
    endtask

    initial begin
        int n;
        bit bad;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check_rst_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("lenlo_s_ready", bus.s_ready, 1);
        check("lenlo_busy",    busy,        0);

        // Reference image at full rate, then with 3-cycle gaps.
        img_q = '{8'h02, 8'h00, 8'hb3, 8'h81, 8'h20, 8'h00, 8'h33, 8'h82, 8'h30, 8'h40};
        add_csum(1'b0);
        run_load("tp_full", 0, 0, 1'b0);
        check("tp_full_w0", (got_q.size() > 0) ? got_q[0] : '1, {8'h00, 32'h002081b3});
        check("tp_full_w1", (got_q.size() > 1) ? got_q[1] : '1, {8'h01, 32'h40308233});
        run_load("tp_gap3", 3, 3, 1'b0);
        check("tp_gap3_w1", (got_q.size() > 1) ? got_q[1] : '1, {8'h01, 32'h40308233});

        // Empty image.
        img_q = '{8'h00, 8'h00};
        add_csum(1'b0);
        run_load("n0", 0, 0, 1'b0);

        // Oversized image, then reload.
        img_q = '{8'h01, 8'h01};
        run_load("ovf", 0, 0, 1'b0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("ovf_rl_error",    error,       0);
        check("ovf_rl_done",     done,        0);
        check("ovf_rl_core_rst", core_rst,    1);
        check("ovf_rl_s_ready",  bus.s_ready, 1);
        check("ovf_rl_busy",     busy,        0);

        // Reset after 6 payload bytes of a 2-word image.
        img_q = '{8'h02, 8'h00, 8'hb3, 8'h81, 8'h20, 8'h00, 8'h33, 8'h82};
        got_q.delete();
        for (int i = 0; i < img_q.size(); i++) send_byte(img_q[i]);
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_rst_vals("midrst");
        check("midrst_nwrites", got_q.size(), 1);
        check("midrst_w0", (got_q.size() > 0) ? got_q[0] : '1, {8'h00, 32'h002081b3});
        @(negedge clk);
        rst_n = 1'b1;
        img_q = '{8'h02, 8'h00, 8'hb3, 8'h81, 8'h20, 8'h00, 8'h33, 8'h82, 8'h30, 8'h40};
        add_csum(1'b0);
        run_load("after_rst", 0, 0, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        img_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_load("cs_ok", 0, 0, 1'b0);
        check("cs_ok_done", done, 1);
        img_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        run_load("cs_bad", 0, 0, 1'b0);
        check("cs_bad_error", error, 1);
        check("cs_bad_w0", (got_q.size() > 0) ? got_q[0] : '1, {8'h00, 32'h00000013});
`endif

        // Randomized small images with random gaps and ignored reload noise.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(6, 1);
`ifdef BOOT_CHECKSUM_EN
            bad = ($urandom_range(3, 0) == 0);
`else
            bad = 1'b0;
`endif
            make_img(n, bad);
            run_load($sformatf("rnd%0d", t), 0, 2, 1'b1);
        end

        // Boundary: full-depth image at full rate, then a random oversized length.
        make_img(int'(DEPTH), 1'b0);
        run_load("full_depth", 0, 0, 1'b0);
        make_img($urandom_range(65535, DEPTH + 1), 1'b0);
        run_load("rnd_ovf", 0, 0, 1'b0);

        check("status_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
